fpmul_issue_stage: RTL and testbench

- Issue/collect wrapper placed directly around the 4-stage FP32 pipelined multiplier.
- Upstream side: accepts operand pairs with a valid/ready handshake and classifies special operands (zero/denormal, inf, NaN).
- Multiplier side: drives the multiplier's A/B inputs and tracks each issued operation through a valid/tag delay line matched to the multiplier latency.
- Downstream side: captures F, or a special-case override, into a result FIFO. Credit-based issue gives full downstream back-pressure even though the multiplier pipeline cannot stall.

---
 rtl/fpmul_issue_stage.sv | 189 ++++++++++++++++++
 tb/tb_fpmul_issue_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_issue_stage.sv
// Issue/collect wrapper around the 4-stage FP32 multiplier. It provides credit-based issue,
// special-operand override, a latency-matched delay line and a FWFT result FIFO.
// Optional per-result flags port: define FPMUL_ISSUE_FLAGS_EN.
module fpmul_issue_stage #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic [31:0]      mul_f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef FPMUL_ISSUE_FLAGS_EN
    ,
    output logic [2:0]       out_flags
`endif
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;

    logic        a_zero, a_inf, a_nan;
    logic        b_zero, b_inf, b_nan;
    logic        sgn;
    logic        ovr;
    logic [31:0] ovr_val;

    logic             accept, pop, wr_en;
    logic [31:0]      wr_data;
    logic [CNT_W-1:0] cnt, cnt_nxt, occ, occ_nxt;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    logic [LAT:0]     dl_valid;
    logic [LAT:0]     dl_ovr;
    logic [TAG_W-1:0] dl_tag [LAT+1];
    logic [31:0]      dl_val [LAT+1];

    logic [31:0]      mem_data [DEPTH];
    logic [TAG_W-1:0] mem_tag  [DEPTH];

    // Operand classification; denormals are flushed to zero.
    assign a_zero = (in_a[30:23] == 8'h00);
    assign b_zero = (in_b[30:23] == 8'h00);
    assign a_inf  = (in_a[30:23] == 8'hFF) && (in_a[22:0] == 23'h0);
    assign b_inf  = (in_b[30:23] == 8'hFF) && (in_b[22:0] == 23'h0);
    assign a_nan  = (in_a[30:23] == 8'hFF) && (in_a[22:0] != 23'h0);
    assign b_nan  = (in_b[30:23] == 8'hFF) && (in_b[22:0] != 23'h0);
    assign sgn    = in_a[31] ^ in_b[31];

    always_comb begin
        ovr     = 1'b0;
        ovr_val = 32'h0;
        if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
            ovr     = 1'b1;
            ovr_val = QNAN;
        end else if (a_inf | b_inf) begin
            ovr     = 1'b1;
            ovr_val = {sgn, 8'hFF, 23'h0};
        end else if (a_zero | b_zero) begin
            ovr     = 1'b1;
            ovr_val = {sgn, 31'h0};
        end
    end

    assign accept   = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign wr_en    = dl_valid[LAT];
    assign wr_data  = dl_ovr[LAT] ? dl_val[LAT] : mul_f;
    assign out_data = mem_data[rd_ptr];
    assign out_tag  = mem_tag[rd_ptr];

    always_comb begin
        cnt_nxt = cnt;
        if (accept && !pop) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else if (pop && !accept) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
        occ_nxt = occ;
        if (wr_en && !pop) begin
            occ_nxt = occ + CNT_W'(1);
        end else if (pop && !wr_en) begin
            occ_nxt = occ - CNT_W'(1);
        end
    end

    // Credits: in_ready comes from a register only, so there is no path from out_ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            in_ready <= 1'b0;
            mul_a    <= 32'h0;
            mul_b    <= 32'h0;
        end else begin
            cnt      <= cnt_nxt;
            in_ready <= (cnt_nxt < CNT_W'(DEPTH));
            if (accept) begin
                mul_a <= in_a;
                mul_b <= in_b;
            end
        end
    end

    // Delay line aligned with the multiplier output; stage LAT pairs with mul_f.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dl_valid <= '0;
            dl_ovr   <= '0;
            for (int unsigned i = 0; i <= LAT; i++) begin
                dl_tag[i] <= '0;
                dl_val[i] <= 32'h0;
            end
        end else begin
            dl_valid  <= {dl_valid[LAT-1:0], accept};
            dl_ovr    <= {dl_ovr[LAT-1:0], ovr};
            dl_tag[0] <= in_tag;
            dl_val[0] <= ovr_val;
            for (int unsigned i = 1; i <= LAT; i++) begin
                dl_tag[i] <= dl_tag[i-1];
                dl_val[i] <= dl_val[i-1];
            end
        end
    end

    // Result FIFO. A write never overflows because credits reserve its slot at issue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            out_valid <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_data[i] <= 32'h0;
                mem_tag[i]  <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_data[wr_ptr] <= wr_data;
                mem_tag[wr_ptr]  <= dl_tag[LAT];
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ       <= occ_nxt;
            out_valid <= (occ_nxt != '0);
        end
    end

`ifdef FPMUL_ISSUE_FLAGS_EN
    logic [2:0] wr_flags;
    logic [2:0] mem_flags [DEPTH];

    // Flags for an override are recovered from the stored override value.
    always_comb begin
        wr_flags = 3'b000;
        if (dl_ovr[LAT]) begin
            wr_flags[2] = (dl_val[LAT][22:0] != 23'h0);
            wr_flags[1] = (dl_val[LAT][30:23] == 8'hFF) && (dl_val[LAT][22:0] == 23'h0);
            wr_flags[0] = (dl_val[LAT][30:23] == 8'h00);
        end else begin
            wr_flags[0] = (mul_f[30:0] == 31'h0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_flags[i] <= 3'b000;
            end
        end else if (wr_en) begin
            mem_flags[wr_ptr] <= wr_flags;
        end
    end

    assign out_flags = mem_flags[rd_ptr];
`endif

endmodule

// File: tb/tb_fpmul_issue_stage.sv
// Self-checking bench for fpmul_issue_stage: directed literal cases plus randomized
// traffic compared every cycle against a queue-based reference model.
module tb_fpmul_issue_stage;
    localparam int DEPTH = 4;
    localparam int LAT   = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a, in_b;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      mul_a, mul_b, mul_f;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
`ifdef FPMUL_ISSUE_FLAGS_EN
    logic [2:0]       out_flags;
`endif

    fpmul_issue_stage #(.DEPTH(DEPTH), .LAT(LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .mul_a(mul_a), .mul_b(mul_b), .mul_f(mul_f),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
`ifdef FPMUL_ISSUE_FLAGS_EN
        , .out_flags(out_flags)
`endif
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: four register stages returning mul_a ^ mul_b.
    logic [31:0] s0 = 0, s1 = 0, s2 = 0, s3 = 0;
    always @(posedge clk) begin
        s0 <= mul_a ^ mul_b;
        s1 <= s0;
        s2 <= s1;
        s3 <= s2;
    end
    assign mul_f = s3;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model.
    typedef struct {
        int          due;
        logic [31:0] data;
        logic [3:0]  tag;
        logic [2:0]  flags;
    } ent_t;

    ent_t        m_pipe[$];
    ent_t        m_fifo[$];
    int          m_cnt = 0;
    bit          m_ready = 1'b0;
    logic [31:0] m_last_a = 0, m_last_b = 0;
    int          cyc = 0;

    // 0 zero/denormal, 1 normal, 2 infinity, 3 NaN
    function automatic int cls(input logic [31:0] x);
        int e = int'((x >> 23) & 32'hFF);
        int f = int'(x & 32'h7FFFFF);
        if (e == 0) return 0;
        if (e == 255) return (f != 0) ? 3 : 2;
        return 1;
    endfunction

    function automatic ent_t ref_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        ent_t r;
        int ca = cls(a);
        int cb = cls(b);
        bit s = a[31] ^ b[31];
        logic [31:0] x = a ^ b;
        r.due = 0;
        r.tag = t;
        if (ca == 3 || cb == 3 || (ca == 2 && cb == 0) || (ca == 0 && cb == 2)) begin
            r.data = 32'h7FC00000;                   r.flags = 3'b100;
        end else if (ca == 2 || cb == 2) begin
            r.data = s ? 32'hFF800000 : 32'h7F800000; r.flags = 3'b010;
        end else if (ca == 0 || cb == 0) begin
            r.data = s ? 32'h80000000 : 32'h0;        r.flags = 3'b001;
        end else begin
            r.data  = x;
            r.flags = ((x & 32'h7FFFFFFF) == 0) ? 3'b001 : 3'b000;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        ent_t e;
        bit acc, pp;
        cyc++;
        if (!rst) begin
            m_pipe.delete();
            m_fifo.delete();
            m_cnt    = 0;
            m_ready  = 1'b0;
            m_last_a = 0;
            m_last_b = 0;
        end else begin
            acc = in_valid && m_ready;
            pp  = (m_fifo.size() != 0) && out_ready;
            if (pp) void'(m_fifo.pop_front());
            while (m_pipe.size() != 0 && m_pipe[0].due == cyc) m_fifo.push_back(m_pipe.pop_front());
            if (acc) begin
                e     = ref_op(in_a, in_b, in_tag);
                e.due = cyc + LAT + 1;
                m_pipe.push_back(e);
                m_last_a = in_a;
                m_last_b = in_b;
            end
            m_cnt   = m_cnt + int'(acc) - int'(pp);
            m_ready = (m_cnt < DEPTH);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(m_ready));
            chk("out_valid", 32'(out_valid), 32'(m_fifo.size() != 0));
            chk("mul_a", mul_a, m_last_a);
            chk("mul_b", mul_b, m_last_b);
            if (m_fifo.size() != 0) begin
                chk("out_data", out_data, m_fifo[0].data);
                chk("out_tag", 32'(out_tag), 32'(m_fifo[0].tag));
`ifdef FPMUL_ISSUE_FLAGS_EN
                chk("out_flags", 32'(out_flags), 32'(m_fifo[0].flags));
`endif
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        int n = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = t;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [31:0] d, input logic [3:0] t,
                              input logic [2:0] f, output int lat);
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_data"}, out_data, d);
        chk({nm, "_tag"}, 32'(out_tag), 32'(t));
`ifdef FPMUL_ISSUE_FLAGS_EN
        chk({nm, "_flags"}, 32'(out_flags), 32'(f));
`else
        if (f == 3'b111) $display("unused flag pattern");
`endif
        lat = n;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_op();
        logic s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
            0:       return {s, 31'h0};
            1:       return {s, 8'h00, 23'($urandom)};
            2:       return {s, 8'hFF, 23'h0};
            3:       return {s, 8'hFF, 23'($urandom) | 23'h1};
            default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    int lat;
    int idx;
    bit will;

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_a = 0; in_b = 0; in_tag = 0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_mul_a", mul_a, 32'd0);
        chk("rst_mul_b", mul_b, 32'd0);
        chk_en = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        send(32'h40000000, 32'h40400000, 4'd3);
        expect_out("basic", 32'h00400000, 4'd3, 3'b000, lat);
        chk("basic_latency", 32'(lat), 32'd5);
        send(32'h80000000, 32'h3F800000, 4'd1);
        expect_out("zero_ovr", 32'h80000000, 4'd1, 3'b001, lat);
        send(32'h7F800000, 32'h00000000, 4'd2);
        expect_out("inf_x_zero", 32'h7FC00000, 4'd2, 3'b100, lat);
        send(32'hFF800000, 32'h40000000, 4'd4);
        expect_out("neg_inf", 32'hFF800000, 4'd4, 3'b010, lat);
        repeat (3) @(negedge clk);

        // Back-pressure: six offers against a stalled output.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; in_a = 32'h3F800000 | 32'(idx); in_b = 32'h40000000; in_tag = 4'(idx);
            will = in_ready;
            @(negedge clk);
            if (will) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd4);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        repeat (6) @(negedge clk);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("bp_order_tag", 32'(out_tag), 32'(j));
            if (j == 0) chk("full_pop_ready", 32'(in_ready), 32'd0);
            will = in_ready;
            @(negedge clk);
            if (will && in_valid) begin
                idx++;
                in_a = 32'h3F800000 | 32'(idx); in_tag = 4'(idx);
                if (idx == 6) in_valid = 1'b0;
            end
            if (j == 0) chk("full_pop_next_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        repeat (12) @(negedge clk);

        // Reset with operations in flight.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_a = 32'h3FC00000 + 32'(k); in_b = 32'h40000000; in_tag = 4'(8 + k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rst_flight_out_valid", 32'(out_valid), 32'd0);
            if (k == 0) chk("rst_release_ready", 32'(in_ready), 32'd1);
        end
        send(32'h40800000, 32'h40000000, 4'd7);
        expect_out("post_rst", 32'h00800000, 4'd7, 3'b000, lat);
        chk("post_rst_latency", 32'(lat), 32'd5);

        // Randomized traffic; the first half keeps the output mostly stalled.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = rnd_op();
            in_b      = ($urandom_range(0, 7) == 0) ? (in_a ^ 32'h80000000) : rnd_op();
            in_tag    = 4'($urandom);
            out_ready = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_in_ready", 32'(in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
